// File: rtl/imem_dmem_bus_arbiter.sv
// imem_dmem_bus_arbiter: round-robin share of one memory bus between I-refill (i_*) and D-refill/writeback (d_*) ports, master side m_*, with silent drain of aborted I bursts
module imem_dmem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [LEN_W-1:0]    i_len,
  output logic                i_ready,
  input  logic                i_abort,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [LEN_W-1:0]    d_len,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  output logic                d_bvalid,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [LEN_W-1:0]    m_len,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_bvalid
);
  typedef enum logic [2:0] {IDLE, REQ_I, RESP_I, REQ_D, RESP_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d, abort_q, abort_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [LEN_W:0] cnt_q, cnt_d;
  logic pick_d, resp_rd, beat, abort_now;
  assign pick_d    = d_req && (!i_req || !last_d_q);
  assign resp_rd   = (state_q == RESP_I) || (state_q == RESP_D && !we_q);
  assign beat      = resp_rd && m_rvalid;
  assign abort_now = abort_q || i_abort;
  assign i_rvalid  = state_q == RESP_I && m_rvalid && !abort_now;
  assign i_rlast   = i_rvalid && m_rlast;
  assign i_rdata   = i_rvalid ? m_rdata : '0;
  assign d_rvalid  = state_q == RESP_D && !we_q && m_rvalid;
  assign d_rlast   = d_rvalid && m_rlast;
  assign d_rdata   = d_rvalid ? m_rdata : '0;
  assign d_bvalid  = state_q == RESP_D && we_q && m_bvalid;
  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_len     = len_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    abort_d  = abort_q;
    we_d     = we_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = state_q == IDLE ? '0 : cnt_q + {{LEN_W{1'b0}}, beat};
    m_req    = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state_q)
      IDLE: if (i_req || d_req) begin
        state_d  = pick_d ? REQ_D : REQ_I;
        last_d_d = pick_d;
        we_d     = pick_d && d_we;
        addr_d   = pick_d ? d_addr : i_addr;
        len_d    = pick_d ? (d_we ? '0 : d_len) : i_len;
        wdata_d  = pick_d ? d_wdata : '0;
        wstrb_d  = pick_d ? d_wstrb : '0;
      end
      REQ_I: begin
        m_req   = 1'b1;
        abort_d = abort_now;
        i_ready = m_ready;
        state_d = m_ready ? RESP_I : REQ_I;
      end
      RESP_I: begin
        abort_d = abort_now && !(m_rvalid && m_rlast);
        state_d = m_rvalid && m_rlast ? IDLE : RESP_I;
      end
      REQ_D: begin
        m_req   = 1'b1;
        d_ready = m_ready;
        state_d = m_ready ? RESP_D : REQ_D;
      end
      RESP_D: state_d = (we_q ? m_bvalid : m_rvalid && m_rlast) ? IDLE : RESP_D;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      abort_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      abort_q  <= abort_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
    end
  end
  assert property (@(posedge clk) disable iff (rst) beat && m_rlast |-> cnt_q == {1'b0, len_q});
  assert property (@(posedge clk) disable iff (rst) beat && !m_rlast |-> cnt_q < {1'b0, len_q});
endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// tb_imem_dmem_bus_arbiter: directed scoreboard bench for imem_dmem_bus_arbiter
module tb_imem_dmem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 0, i_abort = 0, d_req = 0, d_we = 0, m_ready = 0, m_rvalid = 0, m_rlast = 0, m_bvalid = 0;
  logic [31:0] i_addr = 0, d_addr = 0;
  logic [3:0] i_len = 0, d_len = 0;
  logic [63:0] d_wdata = 0, m_rdata = 0;
  logic [7:0] d_wstrb = 0;
  logic i_ready, i_rvalid, i_rlast, d_ready, d_rvalid, d_rlast, d_bvalid, m_req, m_we;
  logic [63:0] i_rdata, d_rdata, m_wdata;
  logic [31:0] m_addr;
  logic [3:0] m_len;
  logic [7:0] m_wstrb;
  imem_dmem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_ready(i_ready), .i_abort(i_abort),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_bvalid(d_bvalid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_bvalid(m_bvalid)
  );
  always #5 clk = ~clk;
  localparam int K_ACC = 0, K_IRDY = 1, K_DRDY = 2, K_IRV = 3, K_DRV = 4, K_BV = 5;
  typedef struct {int k; logic [64:0] v;} ev_t;
  ev_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  function automatic logic [64:0] acc(logic we, logic [3:0] len, logic [7:0] st, logic [31:0] a);
    return {20'b0, we, len, st, a};
  endfunction
  task automatic push(int k, logic [64:0] v);
    ev_t e;
    e.k = k;
    e.v = v;
    exp_q.push_back(e);
  endtask
  task automatic chk(string name, logic [64:0] got, logic [64:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask
  task automatic mon(int k, logic [64:0] v, string name);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got unexpected event val %h, required none", name, v);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.v !== v) begin
        miscompares++;
        $display("FAIL %s: got kind %0d val %h, required kind %0d val %h", name, k, v, e.k, e.v);
      end
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (m_req && m_ready) mon(K_ACC, {20'b0, m_we, m_len, m_wstrb, m_addr}, "m_accept");
    if (i_ready) mon(K_IRDY, 65'd0, "i_ready");
    if (d_ready) mon(K_DRDY, 65'd0, "d_ready");
    if (i_rvalid) mon(K_IRV, {i_rlast, i_rdata}, "i_rvalid");
    if (d_rvalid) mon(K_DRV, {d_rlast, d_rdata}, "d_rvalid");
    if (d_bvalid) mon(K_BV, 65'd0, "d_bvalid");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reqi(logic [31:0] a, logic [3:0] l);
    i_req = 1;
    i_addr = a;
    i_len = l;
  endtask
  task automatic reqd(logic we, logic [31:0] a, logic [3:0] l, logic [63:0] wd, logic [7:0] st);
    d_req = 1;
    d_we = we;
    d_addr = a;
    d_len = l;
    d_wdata = wd;
    d_wstrb = st;
  endtask
  task automatic wait_mreq(string name);
    int n = 0;
    while (!m_req && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (!m_req) begin
      miscompares++;
      $display("FAIL %s: m_req timeout, got 0, required 1", name);
    end
  endtask
  task automatic grant(logic d, logic we, logic [3:0] l, logic [7:0] st, logic [31:0] a);
    wait_mreq(d ? "d_grant" : "i_grant");
    push(K_ACC, acc(we, l, st, a));
    push(d ? K_DRDY : K_IRDY, 65'd0);
    m_ready = 1;
    tick;
    m_ready = 0;
    if (d) d_req = 0;
    else i_req = 0;
  endtask
  task automatic beat(logic d, logic [63:0] data, logic last, logic deliver);
    if (deliver) push(d ? K_DRV : K_IRV, {last, data});
    m_rvalid = 1;
    m_rdata = data;
    m_rlast = last;
    tick;
    m_rvalid = 0;
    m_rlast = 0;
    m_rdata = 0;
  endtask
  task automatic bresp;
    push(K_BV, 65'd0);
    m_bvalid = 1;
    tick;
    m_bvalid = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_readies", {i_ready, d_ready}, 0);
    chk("rst_valids", {i_rvalid, d_rvalid, d_bvalid, i_rlast, d_rlast}, 0);
    chk("rst_m_fields", {m_we, m_len, m_wstrb, m_addr}, 0);
    rst = 0;
    tick;
    reqi(32'h8000_0000, 4'd1);
    tick;
    chk("i_only_latency", m_req, 1);
    grant(0, 0, 4'd1, 8'h00, 32'h8000_0000);
    beat(0, 64'hA, 0, 1);
    beat(0, 64'hB, 1, 1);
    chk("i_only_bubble", m_req, 0);
    tick;
    reqi(32'h1000, 4'd0);
    reqd(0, 32'h2000, 4'd1, 64'd0, 8'h00);
    tick;
    grant(1, 0, 4'd1, 8'h00, 32'h2000);
    beat(1, 64'h21, 0, 1);
    beat(1, 64'h22, 1, 1);
    chk("tie_bubble", m_req, 0);
    grant(0, 0, 4'd0, 8'h00, 32'h1000);
    beat(0, 64'h11, 1, 1);
    reqi(32'h1100, 4'd1);
    reqd(0, 32'h2100, 4'd0, 64'd0, 8'h00);
    tick;
    grant(1, 0, 4'd0, 8'h00, 32'h2100);
    beat(1, 64'h31, 1, 1);
    grant(0, 0, 4'd1, 8'h00, 32'h1100);
    beat(0, 64'h12, 0, 1);
    beat(0, 64'h13, 1, 1);
    reqd(1, 32'h3000, 4'd3, 64'h1122_3344_5566_7788, 8'h0F);
    tick;
    chk("wr_m_req", m_req, 1);
    chk("wr_wdata", m_wdata, 64'h1122_3344_5566_7788);
    grant(1, 1, 4'd0, 8'h0F, 32'h3000);
    m_rvalid = 1;
    m_rlast = 1;
    tick;
    m_rvalid = 0;
    m_rlast = 0;
    bresp;
    m_rvalid = 1;
    m_rlast = 1;
    tick;
    m_rvalid = 0;
    m_rlast = 0;
    reqi(32'h4000, 4'd3);
    tick;
    grant(0, 0, 4'd3, 8'h00, 32'h4000);
    beat(0, 64'h41, 0, 1);
    i_abort = 1;
    beat(0, 64'h42, 0, 0);
    i_abort = 0;
    beat(0, 64'h43, 0, 0);
    beat(0, 64'h44, 1, 0);
    chk("abort_bubble", m_req, 0);
    reqi(32'h5000, 4'd1);
    tick;
    grant(0, 0, 4'd1, 8'h00, 32'h5000);
    beat(0, 64'h51, 0, 1);
    beat(0, 64'h52, 1, 1);
    reqd(0, 32'h6000, 4'd1, 64'd0, 8'h00);
    tick;
    grant(1, 0, 4'd1, 8'h00, 32'h6000);
    m_rvalid = 1;
    m_rdata = 64'h61;
    #1;
    chk("rst_pre_fwd", {d_rvalid, d_rdata}, {1'b1, 64'h61});
    #1;
    rst = 1;
    #1;
    chk("async_m_req", m_req, 0);
    chk("async_d_out", {d_rvalid, d_rlast, d_ready, d_rdata}, 0);
    chk("async_m_addr", m_addr, 0);
    @(posedge clk);
    #1;
    m_rvalid = 0;
    m_rdata = 0;
    rst = 0;
    reqi(32'h7000, 4'd0);
    reqd(0, 32'h7100, 4'd0, 64'd0, 8'h00);
    tick;
    grant(1, 0, 4'd0, 8'h00, 32'h7100);
    beat(1, 64'h71, 1, 1);
    grant(0, 0, 4'd0, 8'h00, 32'h7000);
    beat(0, 64'h70, 1, 1);
    reqi(32'h8000, 4'd1);
    tick;
    grant(0, 0, 4'd1, 8'h00, 32'h8000);
    beat(0, 64'h81, 0, 1);
    reqd(0, 32'h9000, 4'd0, 64'd0, 8'h00);
    beat(0, 64'h82, 1, 1);
    chk("held_bubble", m_req, 0);
    tick;
    chk("held_grant", {m_req, m_addr}, {1'b1, 32'h9000});
    grant(1, 0, 4'd0, 8'h00, 32'h9000);
    beat(1, 64'h91, 1, 1);
    repeat (3) tick;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
